// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch with a 2-entry prefetch FIFO.
// Issues halfword fetches, buffers returned words, handles redirects.
//
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   fetch_en           : allow new memory requests
//   imem_req/imem_addr : memory request and byte address
//   imem_ack/rdata     : memory response strobe and data
//   branch_valid/target: one-cycle redirect (target bit 0 forced 0)
//   ir_ready           : instruction register can load
//   ir_wen/inst/pc     : instruction register load, word, address
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  input  logic        branch_valid,
  input  logic [15:0] branch_target,
  input  logic        ir_ready,
  output logic        ir_wen,
  output logic [15:0] ir_inst,
  output logic [15:0] ir_pc
);

  localparam logic [15:0] NOP = 16'h4300;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t      r_state;
  logic [15:0] r_pc;
  logic [15:0] r_req_addr;
  logic [15:0] r_inst [2];
  logic [15:0] r_iaddr [2];
  logic        r_rd;
  logic [1:0]  r_count;

  logic        w_push;
  logic        w_pop;
  logic        w_wr;
  logic [1:0]  w_count_nx;
  logic        w_issue;
  logic        w_unused;

  assign w_unused = branch_target[0];

  assign imem_req  = (r_state != S_IDLE);
  assign imem_addr = r_req_addr;

  assign ir_wen  = (r_count != 2'd0) && ir_ready && !branch_valid;
  assign ir_inst = (r_count != 2'd0) ? r_inst[r_rd]  : NOP;
  assign ir_pc   = (r_count != 2'd0) ? r_iaddr[r_rd] : r_pc;

  assign w_push = (r_state == S_FETCH) && imem_ack && !branch_valid;
  assign w_pop  = ir_wen;

  // write slot sits just past the valid entries
  assign w_wr = r_rd ^ r_count[0];

  assign w_count_nx = r_count
                    + {1'b0, w_push}
                    - {1'b0, w_pop};

  // IDLE looks at the current occupancy; FETCH at the post-update one
  always_comb begin
    w_issue = 1'b0;
    if (!branch_valid) begin
      unique case (r_state)
        S_IDLE:  w_issue = fetch_en && !r_count[1];
        S_FETCH: w_issue = imem_ack && fetch_en
                           && !w_count_nx[1];
        default: w_issue = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_count    <= 2'd0;
      r_rd       <= 1'b0;
    end else if (branch_valid) begin
      // redirect beats push, pop and issue
      r_count <= 2'd0;
      r_pc    <= {branch_target[15:1], 1'b0};
      unique case (r_state)
        S_FETCH: begin
          r_state <= imem_ack ? S_IDLE : S_DISCARD;
        end
        S_DISCARD: begin
          // only leave once the in-flight word has come back
          if (imem_ack) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end else begin
      if (w_push) begin
        r_inst[w_wr]  <= imem_rdata;
        r_iaddr[w_wr] <= r_req_addr;
      end
      if (w_pop) r_rd <= ~r_rd;
      r_count <= w_count_nx;

      if (w_issue) begin
        r_req_addr <= r_pc;
        r_pc       <= r_pc + 16'd2;
      end

      unique case (r_state)
        S_IDLE: begin
          if (w_issue) r_state <= S_FETCH;
        end
        S_FETCH: begin
          if (imem_ack && !w_issue) r_state <= S_IDLE;
        end
        S_DISCARD: begin
          if (imem_ack) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, halfword-aligned address of the first fetch after reset.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: one clock; reset is synchronous and active-high.
REQ-004 SHALL have port fetch_en, input, 1 bit: permits new memory requests when high.
REQ-005 SHALL have port imem_req, output, 1 bit: instruction memory request.
REQ-006 SHALL have port imem_addr, output, 16 bits: request byte address.
REQ-007 SHALL have port imem_ack, input, 1 bit: memory returns data this cycle.
REQ-008 SHALL have port imem_rdata, input, 16 bits: instruction word, valid only with imem_ack.
REQ-009 SHALL have port branch_valid, input, 1 bit: one-cycle redirect pulse.
REQ-010 SHALL have port branch_target, input, 16 bits: redirect address, bit 0 ignored (forced 0).
REQ-011 SHALL have port ir_ready, input, 1 bit: instruction register may load this cycle.
REQ-012 SHALL have port ir_wen, output, 1 bit: write enable to instruction register.
REQ-013 SHALL have port ir_inst, output, 16 bits: instruction word to instruction register.
REQ-014 SHALL have port ir_pc, output, 16 bits: address of ir_inst.

Function
REQ-015 SHALL hold pc (next fetch address), req_addr, a 2-entry FIFO of {inst, addr}, 2-bit count, and state in {IDLE, FETCH, DISCARD}.
REQ-016 SHALL drive imem_req=1 exactly when state is FETCH or DISCARD; imem_addr=req_addr, stable while imem_req=1.
REQ-017 IDLE->FETCH SHALL occur when fetch_en=1, count<2, branch_valid=0: req_addr<=pc, pc<=pc+2 (16-bit wrap, 16'hFFFE+2=16'h0000).
REQ-018 In FETCH with imem_ack=1 and branch_valid=0 SHALL push {imem_rdata, req_addr}; then stay FETCH issuing next address if fetch_en=1 and post-update count<2, else go IDLE.
REQ-019 ir_wen SHALL be count!=0 AND ir_ready AND NOT branch_valid; ir_wen pops FIFO head that cycle.
REQ-020 ir_inst/ir_pc SHALL show FIFO head; when count=0, ir_inst=16'h4300 (NOP) and ir_pc=pc.
REQ-021 Simultaneous push and pop SHALL leave count unchanged; push never occurs with count=2 (guaranteed by REQ-017/018 issue rule).
REQ-022 branch_valid=1 SHALL flush FIFO (count<=0), set pc<=branch_target, and take priority over push, pop and issue in that cycle.
REQ-023 Branch in FETCH without ack SHALL go DISCARD; in DISCARD the returning ack data SHALL be dropped, then go IDLE.
REQ-024 Branch in FETCH with ack the same cycle SHALL drop that data and go IDLE; branch in DISCARD SHALL update pc and remain DISCARD; branch in IDLE SHALL stay IDLE.
REQ-025 fetch_en=0 SHALL not abort an outstanding request; data still pushed on ack.
REQ-026 Latency SHALL be: fetch issue 1 cycle after IDLE entry conditions; ack data visible on ir_inst the cycle after ack.

Reset
REQ-027 reset=1 at a clock edge SHALL set pc=RESET_PC, req_addr=RESET_PC, count=0, state=IDLE, overriding all other inputs including mid-request.
REQ-028 While in reset state: imem_req=0, imem_addr=RESET_PC, ir_wen=0, ir_inst=16'h4300, ir_pc=RESET_PC.
REQ-029 An imem_ack arriving after reset for a pre-reset request SHALL be ignored (state IDLE).

Verification
REQ-030 Reset release, fetch_en=1, ack 1 cycle after each req, ir_ready=1 -> imem_addr 0000,0002,0004; ir_wen each cycle after ack with matching ir_pc.
REQ-031 ir_ready=0, ack always 1 -> exactly two pushes, imem_req drops, count=2; ir_ready=1 -> ir_wen two cycles, fetching resumes.
REQ-032 branch_valid with target 16'h0101 while FETCH waiting 3 cycles for ack -> ack data dropped, next imem_addr=16'h0100, no ir_wen until new data.
REQ-033 branch_valid same cycle as ack and ir_ready with count=1 -> ir_wen=0, count=0, data dropped, next request to target.
REQ-034 pc=16'hFFFE fetch -> next imem_addr=16'h0000.
REQ-035 reset asserted while imem_req=1 -> next cycle imem_req=0, ir_inst=16'h4300, later ack ignored.
